// File: rtl/pma_region_table.sv
`default_nettype none
// ============================================================================
// Module      : pma_region_table
// Description : Runtime-programmable physical-memory-attribute table.
//               NrRules regions, each holding base, length and a 4-bit
//               attribute field {L, NI, C, X}. A registered lookup port
//               returns the attributes of the lowest-indexed enabled region
//               containing the address. A single-cycle config port programs
//               and reads back the table.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cfg_req_i/we_i         config request, 1=write 0=read
//   cfg_idx_i/field_i      entry index, field (0 base, 1 length, 2 attr)
//   cfg_wdata_i            write data (attr uses [3:0])
//   cfg_rvalid_o/rdata_o   response pulse and read data, one cycle later
//   cfg_err_o              access error, valid with cfg_rvalid_o
//   lookup_valid_i/addr_i  attribute query
//   result_valid_o         query answer, one cycle later
//   hit_o, match_idx_o     match flag and winning entry
//   exec_o/cached_o/nonidem_o  winning attributes (miss: 0/0/1)
//
// Optional feature (macro PMA_REGION_STATS_EN):
//   miss_count_o           saturating count of missed lookups
//   miss_count_clr_i       synchronous clear, wins over increment
// ============================================================================
module pma_region_table #(
   parameter int unsigned                  NrRules   = 4,
   parameter int unsigned                  AddrWidth = 64,
   parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
   parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
   parameter logic [NrRules*4-1:0]         RstAttr   = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [3:0]           cfg_idx_i,
   input  logic [1:0]           cfg_field_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   output logic                 cfg_rvalid_o,
   output logic [AddrWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 lookup_valid_i,
   input  logic [AddrWidth-1:0] lookup_addr_i,
   output logic                 result_valid_o,
   output logic                 hit_o,
   output logic [3:0]           match_idx_o,
   output logic                 exec_o,
   output logic                 cached_o,
   output logic                 nonidem_o
`ifdef PMA_REGION_STATS_EN
   ,
   output logic [31:0]          miss_count_o,
   input  logic                 miss_count_clr_i
`endif
);

   localparam logic [4:0] NrRulesIdx = 5'(NrRules);

   logic [AddrWidth-1:0] base_q   [NrRules];
   logic [AddrWidth-1:0] base_d   [NrRules];
   logic [AddrWidth-1:0] length_q [NrRules];
   logic [AddrWidth-1:0] length_d [NrRules];
   logic [3:0]           attr_q   [NrRules];
   logic [3:0]           attr_d   [NrRules];

   logic                 cfg_rvalid_q, cfg_rvalid_d;
   logic                 cfg_err_q, cfg_err_d;
   logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;

   logic                 result_valid_q, result_valid_d;
   logic                 hit_q, hit_d;
   logic [3:0]           match_idx_q, match_idx_d;
   logic                 exec_q, exec_d;
   logic                 cached_q, cached_d;
   logic                 nonidem_q, nonidem_d;

   logic [AddrWidth-1:0] sel_base, sel_length;
   logic [3:0]           sel_attr;
   logic                 cfg_bad;

   logic                 found;
   logic [3:0]           win_idx;
   logic [3:0]           win_attr;

   // ---------------------------------------------------------------------
   // Config port: decode, error check, write-back and read mux
   // ---------------------------------------------------------------------
   always_comb begin
      base_d      = base_q;
      length_d    = length_q;
      attr_d      = attr_q;
      sel_base    = '0;
      sel_length  = '0;
      sel_attr    = '0;
      cfg_rdata_d = '0;

      for (int i = 0; i < NrRules; i++) begin
         if (cfg_idx_i == 4'(i)) begin
            sel_base   = base_q[i];
            sel_length = length_q[i];
            sel_attr   = attr_q[i];
         end
      end

      // An out-of-range index selects nothing, so sel_attr[3] is 0 there and
      // the range check alone flags it.
      cfg_bad = ({1'b0, cfg_idx_i} >= NrRulesIdx) || (cfg_field_i == 2'd3) ||
                (cfg_we_i && sel_attr[3]);

      cfg_rvalid_d = cfg_req_i;
      cfg_err_d    = cfg_req_i && cfg_bad;

      if (cfg_req_i && !cfg_bad) begin
         if (cfg_we_i) begin
            for (int i = 0; i < NrRules; i++) begin
               if (cfg_idx_i == 4'(i)) begin
                  case (cfg_field_i)
                     2'd0:    base_d[i]   = cfg_wdata_i;
                     2'd1:    length_d[i] = cfg_wdata_i;
                     2'd2:    attr_d[i]   = cfg_wdata_i[3:0];
                     default: ;
                  endcase
               end
            end
         end else begin
            case (cfg_field_i)
               2'd0:    cfg_rdata_d = sel_base;
               2'd1:    cfg_rdata_d = sel_length;
               2'd2:    cfg_rdata_d = {{(AddrWidth-4){1'b0}}, sel_attr};
               default: cfg_rdata_d = '0;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Lookup: lowest enabled matching entry wins. The end bound is formed one
   // bit wider so a region reaching the top of the address space does not
   // wrap to a small limit.
   // ---------------------------------------------------------------------
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      win_attr = '0;
      for (int i = 0; i < NrRules; i++) begin
         if (!found && (length_q[i] != '0) && (lookup_addr_i >= base_q[i]) &&
             ({1'b0, lookup_addr_i} < ({1'b0, base_q[i]} + {1'b0, length_q[i]}))) begin
            found    = 1'b1;
            win_idx  = 4'(i);
            win_attr = attr_q[i];
         end
      end

      result_valid_d = lookup_valid_i;
      hit_d          = 1'b0;
      match_idx_d    = '0;
      exec_d         = 1'b0;
      cached_d       = 1'b0;
      nonidem_d      = 1'b0;
      if (lookup_valid_i) begin
         hit_d       = found;
         match_idx_d = found ? win_idx : 4'd0;
         exec_d      = found & win_attr[0];
         cached_d    = found & win_attr[1];
         // Unmapped space is treated as non-idempotent.
         nonidem_d   = !found | win_attr[2];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NrRules; i++) begin
            base_q[i]   <= RstBase[i*AddrWidth +: AddrWidth];
            length_q[i] <= RstLength[i*AddrWidth +: AddrWidth];
            attr_q[i]   <= RstAttr[i*4 +: 4];
         end
         cfg_rvalid_q   <= 1'b0;
         cfg_err_q      <= 1'b0;
         cfg_rdata_q    <= '0;
         result_valid_q <= 1'b0;
         hit_q          <= 1'b0;
         match_idx_q    <= '0;
         exec_q         <= 1'b0;
         cached_q       <= 1'b0;
         nonidem_q      <= 1'b0;
      end else begin
         base_q         <= base_d;
         length_q       <= length_d;
         attr_q         <= attr_d;
         cfg_rvalid_q   <= cfg_rvalid_d;
         cfg_err_q      <= cfg_err_d;
         cfg_rdata_q    <= cfg_rdata_d;
         result_valid_q <= result_valid_d;
         hit_q          <= hit_d;
         match_idx_q    <= match_idx_d;
         exec_q         <= exec_d;
         cached_q       <= cached_d;
         nonidem_q      <= nonidem_d;
      end
   end

   assign cfg_rvalid_o   = cfg_rvalid_q;
   assign cfg_err_o      = cfg_err_q;
   assign cfg_rdata_o    = cfg_rdata_q;
   assign result_valid_o = result_valid_q;
   assign hit_o          = hit_q;
   assign match_idx_o    = match_idx_q;
   assign exec_o         = exec_q;
   assign cached_o       = cached_q;
   assign nonidem_o      = nonidem_q;

`ifdef PMA_REGION_STATS_EN
   // Counts on the same edge that registers the missed result.
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      miss_count_d = miss_count_q;
      if (miss_count_clr_i) begin
         miss_count_d = '0;
      end else if (lookup_valid_i && !found && (miss_count_q != 32'hFFFF_FFFF)) begin
         miss_count_d = miss_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         miss_count_q <= '0;
      end else begin
         miss_count_q <= miss_count_d;
      end
   end

   assign miss_count_o = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pma_region_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_pma_region_table
// Description : Directed, table-driven bench for pma_region_table (4 entries,
//               64-bit addresses, entry 0 reset to 0x8000_0000/+0x4000_0000,
//               attr 0x3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pma_region_table;

   typedef struct packed {
      logic        is_cfg;
      logic        we;
      logic [3:0]  idx;
      logic [1:0]  field;
      logic [63:0] data;
      logic        exp_err;
      logic [63:0] exp_rdata;
      logic        exp_hit;
      logic [3:0]  exp_idx;
      logic [2:0]  exp_xcn;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cfg_req_i = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [3:0]  cfg_idx_i = '0;
   logic [1:0]  cfg_field_i = '0;
   logic [63:0] cfg_wdata_i = '0;
   logic        cfg_rvalid_o;
   logic [63:0] cfg_rdata_o;
   logic        cfg_err_o;
   logic        lookup_valid_i = 1'b0;
   logic [63:0] lookup_addr_i = '0;
   logic        result_valid_o;
   logic        hit_o;
   logic [3:0]  match_idx_o;
   logic        exec_o;
   logic        cached_o;
   logic        nonidem_o;
`ifdef PMA_REGION_STATS_EN
   logic [31:0] miss_count_o;
   logic        miss_count_clr_i = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   vec_t vecs_a [27];
   vec_t vecs_b [6];

   always #5 clk_i = ~clk_i;

   pma_region_table #(
      .NrRules   (4),
      .AddrWidth (64),
      .RstBase   ({64'h0, 64'h0, 64'h0, 64'h0000_0000_8000_0000}),
      .RstLength ({64'h0, 64'h0, 64'h0, 64'h0000_0000_4000_0000}),
      .RstAttr   (16'h0003)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cfg_req_i      (cfg_req_i),
      .cfg_we_i       (cfg_we_i),
      .cfg_idx_i      (cfg_idx_i),
      .cfg_field_i    (cfg_field_i),
      .cfg_wdata_i    (cfg_wdata_i),
      .cfg_rvalid_o   (cfg_rvalid_o),
      .cfg_rdata_o    (cfg_rdata_o),
      .cfg_err_o      (cfg_err_o),
      .lookup_valid_i (lookup_valid_i),
      .lookup_addr_i  (lookup_addr_i),
      .result_valid_o (result_valid_o),
      .hit_o          (hit_o),
      .match_idx_o    (match_idx_o),
      .exec_o         (exec_o),
      .cached_o       (cached_o),
      .nonidem_o      (nonidem_o)
`ifdef PMA_REGION_STATS_EN
      ,
      .miss_count_o     (miss_count_o),
      .miss_count_clr_i (miss_count_clr_i)
`endif
   );

   // Config write: response has rvalid, given err, rdata 0.
   function automatic vec_t cw(input logic [3:0] idx, input logic [1:0] field,
                               input logic [63:0] data, input logic err);
      vec_t v = '0;
      v.is_cfg = 1'b1; v.we = 1'b1; v.idx = idx; v.field = field;
      v.data = data; v.exp_err = err;
      return v;
   endfunction

   function automatic vec_t cr(input logic [3:0] idx, input logic [1:0] field,
                               input logic err, input logic [63:0] rdata);
      vec_t v = '0;
      v.is_cfg = 1'b1; v.idx = idx; v.field = field;
      v.exp_err = err; v.exp_rdata = rdata;
      return v;
   endfunction

   // xcn = {exec, cached, nonidem}
   function automatic vec_t lk(input logic [63:0] addr, input logic hit,
                               input logic [3:0] idx, input logic [2:0] xcn);
      vec_t v = '0;
      v.data = addr; v.exp_hit = hit; v.exp_idx = idx; v.exp_xcn = xcn;
      return v;
   endfunction

   function automatic logic [74:0] got_vec();
      return {cfg_rvalid_o, cfg_err_o, cfg_rdata_o, result_valid_o, hit_o,
              match_idx_o, exec_o, cached_o, nonidem_o};
   endfunction

   function automatic logic [74:0] exp_of(input vec_t v);
      if (v.is_cfg)
         return {1'b1, v.exp_err, v.exp_rdata, 1'b0, 1'b0, 4'd0, 3'b000};
      return {1'b0, 1'b0, 64'd0, 1'b1, v.exp_hit, v.exp_idx, v.exp_xcn};
   endfunction

   task automatic check(input string name, input logic [74:0] got, input logic [74:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic idle();
      cfg_req_i      = 1'b0;
      cfg_we_i       = 1'b0;
      lookup_valid_i = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      cfg_req_i      = v.is_cfg;
      cfg_we_i       = v.we;
      cfg_idx_i      = v.idx;
      cfg_field_i    = v.field;
      cfg_wdata_i    = v.data;
      lookup_valid_i = !v.is_cfg;
      lookup_addr_i  = v.data;
      @(posedge clk_i);
      #1;
      idle();
   endtask

   initial begin
      // Programming and query sequence
      vecs_a[0]  = lk(64'h8000_1000, 1'b1, 4'd0, 3'b110);
      vecs_a[1]  = lk(64'hC000_0000, 1'b0, 4'd0, 3'b001);
      vecs_a[2]  = lk(64'hBFFF_FFFF, 1'b1, 4'd0, 3'b110);
      vecs_a[3]  = cw(4'd1, 2'd0, 64'h1_0000, 1'b0);
      vecs_a[4]  = cw(4'd1, 2'd1, 64'h1_0000, 1'b0);
      vecs_a[5]  = cw(4'd1, 2'd2, 64'h1, 1'b0);
      vecs_a[6]  = cw(4'd2, 2'd0, 64'h0, 1'b0);
      vecs_a[7]  = cw(4'd2, 2'd1, 64'h10_0000, 1'b0);
      vecs_a[8]  = cw(4'd2, 2'd2, 64'h4, 1'b0);
      vecs_a[9]  = lk(64'h1_8000, 1'b1, 4'd1, 3'b100);
      vecs_a[10] = lk(64'h2_0000, 1'b1, 4'd2, 3'b001);
      vecs_a[11] = cw(4'd1, 2'd2, 64'h9, 1'b0);
      vecs_a[12] = cw(4'd1, 2'd0, 64'h2_0000, 1'b1);
      vecs_a[13] = cr(4'd1, 2'd0, 1'b0, 64'h1_0000);
      vecs_a[14] = cr(4'd1, 2'd2, 1'b0, 64'h9);
      vecs_a[15] = lk(64'h1_8000, 1'b1, 4'd1, 3'b100);
      vecs_a[16] = cw(4'd5, 2'd0, 64'h1234, 1'b1);
      vecs_a[17] = cr(4'd0, 2'd3, 1'b1, 64'h0);
      vecs_a[18] = cr(4'd4, 2'd0, 1'b1, 64'h0);
      vecs_a[19] = cw(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
      vecs_a[20] = cw(4'd3, 2'd1, 64'h1000, 1'b0);
      vecs_a[21] = cw(4'd3, 2'd2, 64'h2, 1'b0);
      vecs_a[22] = lk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, 3'b010);
      vecs_a[23] = lk(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, 3'b001);
      vecs_a[24] = lk(64'h0, 1'b1, 4'd2, 3'b001);
      vecs_a[25] = cr(4'd0, 2'd1, 1'b0, 64'h4000_0000);
      vecs_a[26] = cr(4'd0, 2'd2, 1'b0, 64'h3);

      // After a mid-stream reset: table back to reset contents, lock cleared
      vecs_b[0] = cr(4'd1, 2'd0, 1'b0, 64'h0);
      vecs_b[1] = cr(4'd1, 2'd2, 1'b0, 64'h0);
      vecs_b[2] = cr(4'd0, 2'd1, 1'b0, 64'h4000_0000);
      vecs_b[3] = lk(64'h8000_1000, 1'b1, 4'd0, 3'b110);
      vecs_b[4] = lk(64'h1_8000, 1'b0, 4'd0, 3'b001);
      vecs_b[5] = cw(4'd1, 2'd0, 64'h2_0000, 1'b0);

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_outputs", got_vec(), 75'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 27; i++) begin
         drive(vecs_a[i]);
         check($sformatf("vec_a[%0d]", i), got_vec(), exp_of(vecs_a[i]));
      end

      // Same-cycle write of entry0 length=0 and lookup of 0x8000_0000
      cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 4'd0; cfg_field_i = 2'd1;
      cfg_wdata_i = 64'h0;
      lookup_valid_i = 1'b1; lookup_addr_i = 64'h8000_0000;
      @(posedge clk_i);
      #1;
      idle();
      check("same_cycle_pre_write", got_vec(), {1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 4'd0, 3'b110});
      drive(lk(64'h8000_0000, 1'b0, 4'd0, 3'b001));
      check("same_cycle_next", got_vec(), {1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 3'b001});

      // Three back-to-back lookups, reset asserted during the second result cycle
      lookup_valid_i = 1'b1; lookup_addr_i = 64'h1_8000;
      @(posedge clk_i);
      #1;
      check("stream_lookup1", got_vec(), {1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 4'd1, 3'b100});
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check("stream_async_reset", got_vec(), 75'd0);
      @(posedge clk_i);
      #1;
      lookup_valid_i = 1'b0;
      check("stream_reset_held", got_vec(), 75'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 6; i++) begin
         drive(vecs_b[i]);
         check($sformatf("vec_b[%0d]", i), got_vec(), exp_of(vecs_b[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pma_region_table.md
Name: pma_region_table

Overview:
- Runtime-programmable physical-memory-attribute table for CVA6: NrRules regions, each with base, length and attributes (executable, cached, non-idempotent, lock).
- Replaces static per-config execute/cached/idempotent rule lists with one parametrised, programmable table.
- Sits beside the MMU/PMP path: one registered lookup port answers per-address attribute queries; a single-outstanding config port programs and reads back the table.

Parameters:
- NrRules, 4, number of region entries (1..16)
- AddrWidth, 64, address width of lookups and of base/length fields
- RstBase, '0, NrRules*AddrWidth packed reset base values (entry 0 in LSBs)
- RstLength, '0, NrRules*AddrWidth packed reset length values
- RstAttr, '0, NrRules*4 packed reset attributes

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_req_i  in  1  config access request
- cfg_we_i  in  1  1=write, 0=read
- cfg_idx_i  in  4  entry index
- cfg_field_i  in  2  0=base, 1=length, 2=attr, 3=reserved
- cfg_wdata_i  in  AddrWidth  write data; attr uses bits [3:0]
- cfg_rvalid_o  out  1  access response, one cycle after request
- cfg_rdata_o  out  AddrWidth  read data
- cfg_err_o  out  1  error flag valid with cfg_rvalid_o
- lookup_valid_i  in  1  lookup request
- lookup_addr_i  in  AddrWidth  lookup address
- result_valid_o  out  1  lookup result valid
- hit_o  out  1  some enabled entry matched
- match_idx_o  out  4  index of winning entry
- exec_o  out  1  attr[0] of winner
- cached_o  out  1  attr[1] of winner
- nonidem_o  out  1  attr[2] of winner

Behaviour:
- Reset is asynchronous, active-high. While rst_i is high:
  - every output is 0;
  - table loads RstBase/RstLength/RstAttr;
  - any in-flight config response or lookup result is discarded.
- Attributes: [0] X, [1] C, [2] NI, [3] L (lock).
- Entry enabled iff length != 0.
- Match: addr >= base AND {1'b0,addr} < {1'b0,base}+{1'b0,length}. The sum is computed at AddrWidth+1 bits, so no wrap-around.
- Priority: lowest matching index wins.
- Lookup timing:
  - 1-cycle latency: result_valid_o = registered lookup_valid_i.
  - Result fields are registered with it, fully pipelined, one lookup per cycle.
- Lookup miss:
  - hit_o=0, match_idx_o=0;
  - exec_o=0, cached_o=0;
  - nonidem_o=1 (unmapped space is treated conservatively).
- Config port:
  - Accepted whenever cfg_req_i=1; no stall.
  - cfg_rvalid_o is pulsed the following cycle.
- Config errors (cfg_err_o=1, table unchanged, cfg_rdata_o=0):
  - cfg_idx_i >= NrRules;
  - cfg_field_i == 3;
  - write to an entry whose L=1.
- Lock is sticky:
  - Set by an attr write with bit3=1; clears only on reset.
  - The write that sets L also updates X/C/NI.
- Read data: attr reads return zero-extended attr[3:0]; base/length reads return full value.
- Same-cycle write and lookup: the lookup sees pre-write table contents. The write is visible to lookups issued the next cycle.
- Same-cycle read and write of an entry cannot occur (single port).
- Back-to-back config accesses are allowed, one per cycle, each answered one cycle later.

Optional Feature:
- Macro: PMA_REGION_STATS_EN.
- Defined:
  - adds output miss_count_o [31:0]: saturating count of lookups with hit_o=0, incremented at result time, holds at 32'hFFFF_FFFF;
  - adds input miss_count_clr_i [1]: synchronous clear, takes priority over increment in the same cycle;
  - counter is reset to 0.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, NrRules=4, RstBase entry0=0x8000_0000, RstLength=0x4000_0000, RstAttr=0x3:
  - lookup 0x8000_1000 -> next cycle result_valid_o=1, hit_o=1, idx=0, exec_o=1, cached_o=1, nonidem_o=0;
  - lookup 0xC000_0000 (top bound, exclusive) -> hit_o=0, nonidem_o=1.
- Overlap priority: entry1 base=0x1_0000 length=0x1_0000 attr=0x1; entry2 base=0x0 length=0x10_0000 attr=0x4; lookup 0x1_8000 -> idx=1, exec_o=1, nonidem_o=0.
- Lock:
  - write attr entry1=0x9 -> rvalid, err=0;
  - write base entry1=0x2_0000 -> err=1;
  - read base entry1 -> 0x1_0000, err=0.
- Bad access: write idx=5 -> err=1; read field=3 -> err=1, rdata=0.
- Overflow bound: base=0xFFFF_FFFF_FFFF_F000, length=0x1000; lookup 0xFFFF_FFFF_FFFF_FFFF -> hit; lookup 0x0 -> no hit from that entry.
- Same cycle write entry0 length=0 with lookup 0x8000_0000 -> hit; the same lookup one cycle later -> hit_o=0.
- Reset mid-stream: 3 back-to-back lookups, rst_i asserted during cycle 2 -> result_valid_o=0 immediately; table back to reset values.
